// File: rtl/latency_memory.sv
// latency_memory: byte-addressed data memory with per-operation stall latency,
// byte enables and a req/done handshake for a multi-cycle CPU datapath.
//
// Handshake: in FREE a high req_rd (or, failing that, req_wr) is accepted on the
// rising edge; busy then stays high for exactly RD_LAT/WR_LAT cycles, after which
// done pulses for one cycle together with valid rdata (reads) or the committed
// write. Requests seen while busy are dropped, never queued.
//
// Optional feature macro: LATMEM_ALIGN_CHECK_EN
//   defined   -> requests whose lane offset bits are non-zero are rejected with
//                a one-cycle err pulse and no stall.
//   undefined -> misaligned accesses wrap bytewise and err is tied low.
module latency_memory #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 4,
    parameter int WR_LAT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_rd,
    input  logic                  req_wr,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            state
);

    localparam int NB      = DATA_W / 8;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic [2:0] {
        FREE        = 3'b000,
        STALL_READ  = 3'b010,
        STALL_WRITE = 3'b001
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NB-1:0]       be_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                done_q;
    logic                err_q;
    logic [DATA_W-1:0]   rd_word;
    logic                misaligned;
    logic                start_rd, start_wr, fin_rd, fin_wr, reject;

    logic [7:0] mem [0:DEPTH-1];

`ifdef LATMEM_ALIGN_CHECK_EN
    localparam int OFF_W = $clog2(NB);
    generate
        if (OFF_W == 0) begin : g_no_off
            assign misaligned = 1'b0;
        end else begin : g_off
            assign misaligned = |addr[OFF_W-1:0];
        end
    endgenerate
`else
    assign misaligned = 1'b0;
`endif

    // State register; reset always returns to FREE, aborting any stall.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= FREE;
        else      state_q <= state_d;
    end

    // Next-state logic and one-cycle control strobes.
    always_comb begin
        state_d  = state_q;
        start_rd = 1'b0;
        start_wr = 1'b0;
        fin_rd   = 1'b0;
        fin_wr   = 1'b0;
        reject   = 1'b0;
        case (state_q)
            FREE: begin
                if (req_rd || req_wr) begin
                    if (misaligned) begin
                        reject = 1'b1;
                    end else if (req_rd) begin
                        start_rd = 1'b1;
                        state_d  = STALL_READ;
                    end else begin
                        start_wr = 1'b1;
                        state_d  = STALL_WRITE;
                    end
                end
            end
            STALL_READ: begin
                if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    fin_rd  = 1'b1;
                    state_d = FREE;
                end
            end
            STALL_WRITE: begin
                if (cnt_q == CNT_W'(WR_LAT - 1)) begin
                    fin_wr  = 1'b1;
                    state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    // Request latch, stall counter, read data and status pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= fin_rd | fin_wr;
            err_q  <= reject;
            if (start_rd || start_wr) begin
                cnt_q  <= '0;
                addr_q <= addr;
            end else if (fin_rd || fin_wr) begin
                cnt_q <= '0;
            end else if (state_q != FREE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (start_wr) begin
                wdata_q <= wdata;
                be_q    <= be;
            end
            if (fin_rd) rdata_q <= rd_word;
        end
    end

    // Little-endian gather of NB consecutive bytes, wrapping at the top.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NB; i++) begin
            rd_word[8*i +: 8] = mem[addr_q + ADDR_W'(i)];
        end
    end

    // Single write commit on the final stall cycle; contents survive reset,
    // and a reset edge suppresses the commit.
    always_ff @(posedge clk) begin
        if (rst && fin_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (be_q[i]) mem[addr_q + ADDR_W'(i)] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign rdata = rdata_q;
    assign done  = done_q;
    assign err   = err_q;
    assign busy  = (state_q != FREE);
    assign state = busy ? 3'b111 : 3'b000;

endmodule

// File: tb/tb_latency_memory.sv
// Testbench for latency_memory: directed steps from the test plan followed by
// random accesses checked against a byte-array reference model.
module tb_latency_memory;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
    localparam int RD_LAT = 4;
    localparam int WR_LAT = 8;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef LATMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              req_rd, req_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        be;
    logic [DATA_W-1:0] rdata;
    logic              busy, done, err;
    logic [2:0]        state;

    int checks = 0;
    int errors = 0;

    logic [7:0]        model_mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] exp_rdata;

    latency_memory #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
        .addr(addr), .wdata(wdata), .be(be), .rdata(rdata),
        .busy(busy), .done(done), .err(err), .state(state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = model_mem[(int'(a) + i) % DEPTH];
        return w;
    endfunction

    task automatic model_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] b);
        for (int i = 0; i < 4; i++)
            if (b[i]) model_mem[(int'(a) + i) % DEPTH] = d[8*i +: 8];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Driver: present one request (called just after an edge), follow it to done.
    // poke drives noise requests during the stall, which must be ignored.
    task automatic access(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                          input logic [31:0] wd, input logic [3:0] b, input bit poke);
        int n;
        int lat;
        req_rd = rd; req_wr = wr; addr = a; wdata = wd; be = b;
        tick();
        req_rd = 1'b0; req_wr = 1'b0;
        addr = ADDR_W'($urandom); wdata = $urandom; be = 4'($urandom);
        if (ALIGN && a[1:0] != 2'b00) begin
            check("err_pulse", 32'(err), 32'd1);
            check("err_busy", 32'(busy), 32'd0);
            check("err_state", 32'(state), 32'd0);
            tick();
            check("err_clear", 32'(err), 32'd0);
            check("err_done", 32'(done), 32'd0);
            check("err_rdata", rdata, exp_rdata);
            return;
        end
        lat = rd ? RD_LAT : WR_LAT;
        if (rd) exp_q.push_back(model_word(a));
        check("stall_busy", 32'(busy), 32'd1);
        check("stall_state", 32'(state), 32'd7);
        n = 0;
        while (!done && n < 40) begin
            if (poke && n == 1) begin
                req_wr = 1'b1; req_rd = 1'b1; wdata = $urandom; be = 4'hF;
            end else begin
                req_wr = 1'b0; req_rd = 1'b0;
            end
            tick();
            n++;
            if (!done && busy !== 1'b1) check("mid_busy", 32'(busy), 32'd1);
        end
        req_rd = 1'b0; req_wr = 1'b0;
        check(rd ? "rd_latency" : "wr_latency", n, lat);
        check("done_busy", 32'(busy), 32'd0);
        check("done_state", 32'(state), 32'd0);
        if (rd) begin
            if (exp_q.size() > 0) exp_rdata = exp_q.pop_front();
            check("rdata", rdata, exp_rdata);
        end else begin
            model_write(a, wd, b);
            check("rdata_hold", rdata, exp_rdata);
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] ra;
        bit                rrd, rwr;
        rst = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
        addr = '0; wdata = '0; be = '0;
        exp_rdata = '0;

        // Reset
        tick(); tick();
        check("rst_rdata", rdata, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        rst = 1'b1;
        tick();

        // Fill the whole array so the model knows every byte
        for (int k = 0; k < DEPTH / 4; k++)
            access(1'b0, 1'b1, ADDR_W'(k * 4), $urandom, 4'hF, 1'b0);

        // Read latency with known bytes
        access(1'b0, 1'b1, 10'h100, 32'h44332211, 4'hF, 1'b0);
        access(1'b1, 1'b0, 10'h100, '0, '0, 1'b0);
        check("plan_read", rdata, 32'h44332211);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);

        // Masked write and read-after-write
        access(1'b0, 1'b1, 10'h100, 32'hAABBCCDD, 4'b0101, 1'b0);
        access(1'b1, 1'b0, 10'h100, '0, '0, 1'b0);
        check("plan_masked", rdata, 32'h44BB22DD);

        // Arbitration: read wins, memory untouched; mid-stall requests ignored
        access(1'b1, 1'b1, 10'h100, 32'h12345678, 4'hF, 1'b1);
        check("plan_arb_rd", rdata, 32'h44BB22DD);
        access(1'b1, 1'b0, 10'h100, '0, '0, 1'b0);
        check("plan_arb_mem", rdata, 32'h44BB22DD);

        // Wrap
        access(1'b0, 1'b1, 10'h3FE, 32'h01020304, 4'hF, 1'b0);
        access(1'b1, 1'b0, 10'h3FC, '0, '0, 1'b0);
        if (!ALIGN) check("plan_wrap_hi", rdata[31:16], 32'h0304);
        access(1'b1, 1'b0, 10'h000, '0, '0, 1'b0);
        if (!ALIGN) check("plan_wrap_lo", rdata[15:0], 32'h0102);

        // Abort: reset during write stall cycle 3
        req_wr = 1'b1; addr = 10'h200; wdata = 32'hDEADBEEF; be = 4'hF;
        tick();
        req_wr = 1'b0;
        tick(); tick(); tick();
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        tick();
        check("abort_state", 32'(state), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rdata", rdata, 32'h0);
        exp_rdata = '0;
        rst = 1'b1;
        for (int k = 0; k < WR_LAT + 2; k++) begin
            tick();
            if (done !== 1'b0) check("abort_no_done", 32'(done), 32'd0);
        end
        access(1'b1, 1'b0, 10'h200, '0, '0, 1'b0);

        // Misaligned request (rejected only with the alignment check)
        access(1'b1, 1'b0, 10'h101, '0, '0, 1'b0);

        // Random accesses against the model
        for (int k = 0; k < 150; k++) begin
            ra  = ADDR_W'($urandom_range(0, DEPTH - 1));
            rrd = 1'($urandom_range(0, 1));
            rwr = rrd ? 1'($urandom_range(0, 1)) : 1'b1;
            access(rrd, rwr, ra, $urandom, 4'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) tick();
        end

        // Final sweep of every aligned word
        for (int k = 0; k < DEPTH / 4; k++)
            access(1'b1, 1'b0, ADDR_W'(k * 4), '0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
